// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared song-entry layout and recorder state encoding
// Used by both the capture (note_recorder) and playback sides of the song memory.
package song_pkg;

   localparam int ENTRY_W  = 19;
   localparam int PIT_LSB  = 14;
   localparam int NOTE_LSB = 4;
   localparam int BEAT_W   = 4;
   localparam int NOTE_W   = PIT_LSB - NOTE_LSB;
   localparam int PIT_W    = ENTRY_W - PIT_LSB;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      RECORD,
      FLUSH,
      DONE
   } rec_state_t;

   function automatic logic [ENTRY_W-1:0] pack_entry(
      input logic [PIT_W-1:0]  pit_f,
      input logic [NOTE_W-1:0] note_f,
      input logic [BEAT_W-1:0] beat_f
   );
      return {pit_f, note_f, beat_f};
   endfunction

endpackage

// File: rtl/rec_edge_detect.sv
// rtl/rec_edge_detect.sv - registered rising-edge detector for the record request
module rec_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= 1'b0;
      end else begin
         prev <= level;
      end
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/note_recorder.sv
// rtl/note_recorder.sv - samples live notes on tempo ticks and writes run-length
// {pitch, note, beat} entries into the song RAM while recording.
module note_recorder
   import song_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int MAX_BEAT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rec_en,
   input  logic                clear,
   input  logic                tick,
   input  logic [NOTE_W-1:0]   note,
   input  logic [PIT_W-1:0]    pitchshift,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [ENTRY_W-1:0]  wr_data,
   output logic [ADDR_W:0]     rec_length,
   output logic                busy,
   output logic                full
);

   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEAT);

   rec_state_t          state, state_n;
   logic [ADDR_W-1:0]   ptr;
   logic [NOTE_W-1:0]   cur_note;
   logic [PIT_W-1:0]    cur_pit;
   logic [BEAT_W-1:0]   cur_beat;
   logic                rec_rise;
   logic                last_slot;
   logic                same_sample;

   logic do_write, do_load, do_inc, do_arm, do_clear_len, do_clear_full, set_full;

   rec_edge_detect u_rec_edge (
      .clk   (clk),
      .rst   (rst),
      .level (rec_en),
      .rise  (rec_rise)
   );

   assign last_slot   = (ptr == {ADDR_W{1'b1}});
   assign same_sample = (note == cur_note) && (pitchshift == cur_pit);
   assign busy        = (state == ARMED) || (state == RECORD) || (state == FLUSH);

   always_comb begin
      state_n       = state;
      do_write      = 1'b0;
      do_load       = 1'b0;
      do_inc        = 1'b0;
      do_arm        = 1'b0;
      do_clear_len  = 1'b0;
      do_clear_full = 1'b0;
      set_full      = 1'b0;
      case (state)
         IDLE: begin
            if (rec_en) begin
               state_n = ARMED;
               do_arm  = 1'b1;
            end else if (clear) begin
               do_clear_len = 1'b1;
            end
         end
         ARMED: begin
            if (!rec_en) begin
               state_n = IDLE;
            end else if (tick && (note != '0)) begin
               do_load = 1'b1;
               state_n = RECORD;
            end
         end
         RECORD: begin
            // A stop request wins over a tick arriving in the same cycle.
            if (!rec_en) begin
               state_n = FLUSH;
            end else if (tick) begin
               if (same_sample && (cur_beat < BEAT_MAX)) begin
                  do_inc = 1'b1;
               end else begin
                  do_write = 1'b1;
                  if (last_slot) begin
                     set_full = 1'b1;
                     state_n  = DONE;
                  end else begin
                     do_load = 1'b1;
                  end
               end
            end
         end
         FLUSH: begin
            do_write = 1'b1;
            set_full = last_slot;
            state_n  = DONE;
         end
         DONE: begin
            if (clear) begin
               do_clear_len  = 1'b1;
               do_clear_full = 1'b1;
               state_n       = IDLE;
            end else if (rec_rise) begin
               do_arm  = 1'b1;
               state_n = ARMED;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         rec_length <= '0;
         full       <= 1'b0;
         ptr        <= '0;
         cur_note   <= '0;
         cur_pit    <= '0;
         cur_beat   <= '0;
      end else begin
         state <= state_n;
         wr_en <= do_write;
         if (do_write) begin
            wr_addr    <= ptr;
            wr_data    <= pack_entry(cur_pit, cur_note, cur_beat);
            ptr        <= ptr + 1'b1;
            rec_length <= {1'b0, ptr} + 1'b1;
         end
         if (do_arm) begin
            ptr        <= '0;
            wr_addr    <= '0;
            rec_length <= '0;
            full       <= 1'b0;
         end
         if (do_clear_len) begin
            rec_length <= '0;
         end
         if (do_clear_full) begin
            full <= 1'b0;
         end
         if (set_full) begin
            full <= 1'b1;
         end
         if (do_load) begin
            cur_note <= note;
            cur_pit  <= pitchshift;
            cur_beat <= BEAT_W'(1);
         end else if (do_inc) begin
            cur_beat <= cur_beat + 1'b1;
         end
      end
   end

endmodule
